adaptimer_axi_rd: RTL and testbench

//  AXI4-Lite read-channel responder for the adaptive timer; the write-side config path is a separate block.

---
 rtl/adaptimer_axi_rd.sv | 112 +++++++++++
 tb/tb_adaptimer_axi_rd.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adaptimer_axi_rd.sv
// AXI4-Lite read responder for the adaptive timer: lo-then-hi snapshot of the 64-bit
// timer, plus status, read counter and snapshot delta, with detection of the timer going backwards.
//
// state | meaning
// IDLE  | ARREADY high, waiting for a read address
// RESP  | RVALID high, registered response held until RREADY
module adaptimer_axi_rd #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [63:0]       adaptimer,
    input  logic              timer_en,
    input  logic              safe_active,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [DATA_W-1:0] S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state, state_next;
    logic        ar_hs;
    logic [2:0]  word;
    logic        unused_addr_bits;
    logic [63:0] snap, prev_snap;
    logic [31:0] rd_count;
    logic        mono_err;
    logic        mono_set, mono_clr;
    logic [63:0] snap_delta;

    assign ar_hs            = (state == S_IDLE) && S_AXI_ARVALID;
    assign word             = S_AXI_ARADDR[4:2];
    assign unused_addr_bits = ^S_AXI_ARADDR[1:0];
    assign snap_delta       = snap - prev_snap;

    // The very first TIME_LO has no meaningful previous snapshot to compare against.
    assign mono_set = ar_hs && (word == 3'd0) && (rd_count != 32'd0) && (adaptimer < snap);
    assign mono_clr = ar_hs && (word == 3'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (S_AXI_ARVALID) state_next = S_RESP;
            S_RESP: if (S_AXI_RREADY)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (state)
            S_IDLE: S_AXI_ARREADY = 1'b1;
            S_RESP: S_AXI_RVALID  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RRESP <= RESP_OKAY;
            case (word)
                3'd0:    S_AXI_RDATA <= adaptimer[31:0];
                3'd1:    S_AXI_RDATA <= snap[63:32];
                3'd2:    S_AXI_RDATA <= {28'h0, mono_err, safe_active, timer_en, 1'b1};
                3'd3:    S_AXI_RDATA <= rd_count;
                3'd4:    S_AXI_RDATA <= snap_delta[31:0];
                default: begin
                    S_AXI_RDATA <= '0;
                    S_AXI_RRESP <= RESP_SLVERR;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            snap      <= '0;
            prev_snap <= '0;
            rd_count  <= '0;
            mono_err  <= 1'b0;
        end else begin
            if (ar_hs && (word == 3'd0)) begin
                snap      <= adaptimer;
                prev_snap <= snap;
                rd_count  <= rd_count + 32'd1;
            end
            mono_err <= mono_set | (mono_err & ~mono_clr);
        end
    end

endmodule

// File: tb/tb_adaptimer_axi_rd.sv
// Directed and randomized read sequences against a 64-bit arithmetic model of the register map.
module tb_adaptimer_axi_rd;

    logic        clock;
    logic        reset;
    logic [63:0] adaptimer;
    logic        timer_en;
    logic        safe_active;
    logic [4:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_snap, m_prev;
    logic [31:0] m_cnt;
    logic        m_mono;

    adaptimer_axi_rd #(.ADDR_W(5), .DATA_W(32)) dut (
        .clock(clock),
        .reset(reset),
        .adaptimer(adaptimer),
        .timer_en(timer_en),
        .safe_active(safe_active),
        .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA),
        .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_snap = '0; m_prev = '0; m_cnt = '0; m_mono = 1'b0;
    endtask

    // Expected response for one accepted read, applying its side effects to the model.
    task automatic model_read(input logic [2:0] w, output logic [31:0] d, output logic [1:0] r);
        r = 2'b00;
        d = '0;
        case (w)
            3'd0: begin
                d = adaptimer[31:0];
                if (m_cnt != 0 && adaptimer < m_snap) m_mono = 1'b1;
                m_prev = m_snap;
                m_snap = adaptimer;
                m_cnt  = m_cnt + 1;
            end
            3'd1: d = m_snap[63:32];
            3'd2: begin
                d = {28'h0, m_mono, safe_active, timer_en, 1'b1};
                m_mono = 1'b0;
            end
            3'd3: d = m_cnt;
            3'd4: d = 32'(m_snap - m_prev);
            default: r = 2'b10;
        endcase
    endtask

    task automatic axi_read(input logic [4:0] addr, input int rdly, input logic keep_ar,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!S_AXI_RVALID && n < 20);
        chk("ar_to_rvalid_latency", 64'(n), 64'd1);
        S_AXI_ARVALID = keep_ar;
        S_AXI_ARADDR  = 5'h00;
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        for (int i = 0; i < rdly; i++) begin
            @(posedge clock); #1;
            chk("bp_rvalid", 64'(S_AXI_RVALID), 64'd1);
            chk("bp_rdata_stable", 64'(S_AXI_RDATA), 64'(data));
            chk("bp_arready", 64'(S_AXI_ARREADY), 64'd0);
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        @(posedge clock); #1;
        S_AXI_RREADY  = 1'b0;
        chk("rvalid_drop", 64'(S_AXI_RVALID), 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input int rdly, input logic keep_ar,
                          output logic [31:0] data);
        logic [31:0] ed;
        logic [1:0]  er, resp;
        model_read(addr[4:2], ed, er);
        axi_read(addr, rdly, keep_ar, data, resp);
        chk({tag, "_rdata"}, 64'(data), 64'(ed));
        chk({tag, "_rresp"}, 64'(resp), 64'(er));
    endtask

    initial begin
        logic [31:0] d;
        int          n;

        reset = 1'b1; adaptimer = '0; timer_en = 1'b0; safe_active = 1'b0;
        S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("rst_arready", 64'(S_AXI_ARREADY), 64'd1);
            chk("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
        end
        chk("rst_rdata", 64'(S_AXI_RDATA), 64'd0);
        chk("rst_rresp", 64'(S_AXI_RRESP), 64'd0);
        reset = 1'b0; S_AXI_ARVALID = 1'b0;
        @(posedge clock); #1;
        rd_chk("rst_count", 5'h0C, 0, 1'b0, d);
        chk("rst_count_zero", 64'(d), 64'd0);
        rd_chk("rst_status", 5'h08, 0, 1'b0, d);
        chk("rst_status_val", 64'(d), 64'h1);
        rd_chk("rst_delta", 5'h10, 0, 1'b0, d);

        adaptimer = 64'h0000_0001_FFFF_FFF0;
        rd_chk("atomic_lo", 5'h00, 0, 1'b0, d);
        chk("atomic_lo_val", 64'(d), 64'hFFFF_FFF0);
        adaptimer = adaptimer + 64'h20;
        rd_chk("atomic_hi", 5'h04, 0, 1'b0, d);
        chk("atomic_hi_val", 64'(d), 64'h1);

        rd_chk("bp_count", 5'h0C, 5, 1'b1, d);
        rd_chk("bp_no_extra_ar", 5'h0C, 0, 1'b0, d);

        adaptimer = 64'h100;
        rd_chk("mono_a", 5'h00, 0, 1'b0, d);
        adaptimer = 64'h80;
        rd_chk("mono_b", 5'h00, 1, 1'b0, d);
        timer_en = 1'b1;
        rd_chk("mono_st1", 5'h08, 0, 1'b0, d);
        chk("mono_bit_set", 64'(d[3]), 64'd1);
        rd_chk("mono_st2", 5'h0B, 0, 1'b0, d);
        chk("mono_bit_clr", 64'(d[3]), 64'd0);

        adaptimer = 64'h1_0000_0000;
        rd_chk("delta_a", 5'h00, 0, 1'b0, d);
        adaptimer = 64'h1_0000_0010;
        rd_chk("delta_b", 5'h01, 0, 1'b0, d);
        rd_chk("delta", 5'h12, 0, 1'b0, d);
        chk("delta_val", 64'(d), 64'h10);

        rd_chk("bad_addr", 5'h1C, 0, 1'b0, d);
        chk("bad_addr_data", 64'(d), 64'd0);
        rd_chk("bad_addr_count", 5'h0C, 0, 1'b0, d);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: adaptimer = {$urandom, $urandom};
                1: adaptimer = adaptimer - 64'($urandom_range(1, 1000));
                default: adaptimer = adaptimer + 64'($urandom_range(0, 70000));
            endcase
            timer_en    = 1'($urandom);
            safe_active = 1'($urandom);
            rd_chk("rand", 5'($urandom), $urandom_range(0, 3), 1'b0, d);
        end

        // Reset during a pending response discards it.
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!S_AXI_RVALID && n < 20);
        chk("rstresp_rvalid", 64'(S_AXI_RVALID), 64'd1);
        S_AXI_ARVALID = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rstresp_drop", 64'(S_AXI_RVALID), 64'd0);
        chk("rstresp_arready", 64'(S_AXI_ARREADY), 64'd1);
        reset = 1'b0;
        model_reset();
        rd_chk("rstresp_count", 5'h0C, 0, 1'b0, d);
        chk("rstresp_count_zero", 64'(d), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
